conv_out_requant: RTL
=====================

Name: conv_out_requant

Overview:
- Downstream stage of the DSP-cascade convolution PE; consumes its 48-bit accumulator stream (P, enable-qualified).
- Rounds and right-shifts each valid result, applies optional ReLU, and saturates to a signed OUT_WIDTH word.
- Tags each word with row-end and frame-end flags from output-position counters.
- Buffers words in a small FIFO and presents them on a valid/ready stream to the next layer or the output BRAM writer. The PE cannot stall, so a full FIFO drops samples and raises a sticky flag.

Parameters:
- KERNEL_SIZE, 3, kernel side; must match the PE.
- FM_SIZE, 4, input feature-map side; must match the PE. OUT_DIM = FM_SIZE-KERNEL_SIZE+1, derived locally.
- ACC_WIDTH, 48, accumulator width from the PE.
- OUT_WIDTH, 8, signed output word width.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_P  in  ACC_WIDTH  signed accumulator from the PE.
- i_valid  in  1  i_P valid this cycle; driven by the PE's o_en.
- i_shift  in  6  right-shift amount, 0..47; quasi-static.
- i_relu_en  in  1  1 = clamp negative results to 0; quasi-static.
- o_data  out  OUT_WIDTH  signed result at the FIFO head.
- o_row_last  out  1  o_data is the last column of an output row.
- o_last  out  1  o_data is the last pixel of the output frame.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts; a transfer happens when o_valid and i_ready are both 1.
- o_overflow  out  1  sticky; a sample was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, internally synchronised deassert):
  - o_valid, o_overflow, o_row_last and o_last = 0; o_data = 0.
  - FIFO pointers, col/row counters and pipeline valid bits = 0.
  - Reset mid-frame discards all pipeline and FIFO contents and restarts counting at pixel (0,0).
- Stage 1, edge k where i_valid=1:
  - Capture r1 = (i_P + rnd) >>> i_shift, computed in ACC_WIDTH+1 bits.
  - rnd = 1<<(i_shift-1) when i_shift>0, else 0. This gives round-half-up; the arithmetic shift keeps sign.
  - Also capture i_relu_en and v1=1.
- Stage 2, edge k+1:
  - r2 = 0 if relu_en and r1<0.
  - Otherwise r2 = clamp(r1, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
  - Compute position flags from counters (col, row):
    - row_last = (col == OUT_DIM-1).
    - last = row_last and (row == OUT_DIM-1).
  - Advance counters: col++, wrapping at OUT_DIM-1 to 0 and incrementing row; row wraps at OUT_DIM-1 to 0.
  - Counters advance on every stage-2 valid, even if the FIFO write is later dropped, so frame alignment survives overflow.
- FIFO write, edge k+2:
  - Push {last, row_last, r2} if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise drop the sample and set o_overflow=1; it stays set until reset.
- FIFO output:
  - First-word fall-through: o_data, o_row_last and o_last reflect the head entry.
  - o_valid=1 from the cycle after edge k+2 when the FIFO was empty. Minimum latency is 3 edges from capture.
- Push and pop together:
  - Occupancy is unchanged; legal when full and when holding one entry.
  - Push into empty with no pop: o_valid rises next cycle.
  - Pop of the last entry with no push: o_valid falls next cycle.
- Throughput: one sample per clock, continuous, no bubbles required.
- Pointers use log2(FIFO_DEPTH)+1 bits (wrap bit) to tell full from empty.
- i_shift and i_relu_en may change only while no sample is in flight; otherwise results are undefined but no state corrupts.
- With KERNEL_SIZE==FM_SIZE, OUT_DIM=1: every word has row_last=1 and last=1.

Test Plan:
- Rounding: i_shift=4, i_relu_en=0, single i_P=37 -> o_data=2 (37+8=45, >>4) after 3 edges. Then i_P=-40 -> o_data=-2 (0xFE). i_P=24 -> o_data=2 (half rounds up).
- ReLU/saturation: i_shift=0. i_P=-100, relu off -> 0x9C; relu on -> 0x00. i_P=1000 -> 0x7F. i_P=-1000 with relu off -> 0x80.
- Framing: FM_SIZE=4, KERNEL_SIZE=3, i_ready=1, 8 consecutive valid samples (values 0..7, shift 0) -> outputs 0..7. row_last=1 on words 1,3,5,7; last=1 on words 3 and 7.
- Overflow: i_ready=0, 5 back-to-back samples 10..14 -> o_valid=1 and o_overflow=1 after the 5th write edge. Raise i_ready -> drains 10,11,12,13, then o_valid=0. The next sample's flags match frame position 5, not 4.
- Simultaneous push/pop at full: FIFO holding 4 entries, i_ready=1 and a new sample arriving at the write edge -> occupancy stays 4, no overflow, order preserved.
- Reset mid-frame: assert i_rst after 2 samples are in the pipeline and 1 is in the FIFO -> o_valid=0 immediately. After release, the next sample is tagged as pixel (0,0) with row_last=0 and last=0.

Source files
------------

// File: rtl/conv_out_requant.sv
// conv_out_requant: requantises the PE's 48-bit accumulator stream into signed
// OUT_WIDTH words. Each word is tagged with row/frame-end flags and buffered in a
// first-word-fall-through FIFO that feeds a valid/ready stream.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_P, i_valid            accumulator sample and its qualifier from the PE
//   i_shift, i_relu_en      quasi-static requant controls
//   o_data, o_row_last,     FIFO head word and its position flags
//   o_last, o_valid
//   i_ready                 consumer accept
//   o_overflow              sticky: a sample was dropped on a full FIFO
module conv_out_requant #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned FM_SIZE     = 4,
    parameter int unsigned ACC_WIDTH   = 48,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ACC_WIDTH-1:0] i_P,
    input  logic                 i_valid,
    input  logic [5:0]           i_shift,
    input  logic                 i_relu_en,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_row_last,
    output logic                 o_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overflow
);

    localparam int unsigned OUT_DIM = FM_SIZE - KERNEL_SIZE + 1;
    localparam int unsigned CNT_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned SUM_W   = ACC_WIDTH + 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = AW + 1;
    localparam int unsigned ENT_W   = OUT_WIDTH + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_DIM - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Reset synchroniser: assert immediately, release two edges after i_rst falls.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst_int = rst_sync_q[1];

    // Stage 1: round-half-up and arithmetic shift; one extra bit absorbs the carry.
    logic [SUM_W-1:0]        rnd;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] r1_d, r1_q;
    logic                    relu_q, v1_q;

    always_comb begin
        rnd = '0;
        if (i_shift != 6'd0) rnd = SUM_W'(1) << (i_shift - 6'd1);
        sum  = $signed({i_P[ACC_WIDTH-1], i_P}) + $signed(rnd);
        r1_d = sum >>> i_shift;
    end

    always_ff @(posedge i_clk or posedge rst_int) begin
        if (rst_int) begin
            r1_q   <= '0;
            relu_q <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                r1_q   <= r1_d;
                relu_q <= i_relu_en;
            end
        end
    end

    // Stage 2: ReLU/saturate and tag with the output position.
    logic [OUT_WIDTH-1:0] r2_d, r2_q;
    logic                 row_last_d, last_d, row_last_q, last_q, v2_q;
    logic [CNT_W-1:0]     col_d, col_q, row_d, row_q;

    always_comb begin
        r2_d       = r1_q[OUT_WIDTH-1:0];
        row_last_d = (col_q == CNT_LAST);
        last_d     = row_last_d && (row_q == CNT_LAST);
        col_d      = col_q;
        row_d      = row_q;
        if (relu_q && r1_q[SUM_W-1])  r2_d = '0;
        else if (r1_q > SAT_MAX)      r2_d = SAT_MAX[OUT_WIDTH-1:0];
        else if (r1_q < SAT_MIN)      r2_d = SAT_MIN[OUT_WIDTH-1:0];
        // Counters track every sample, dropped or not, to keep frame alignment.
        if (v1_q) begin
            if (row_last_d) begin
                col_d = '0;
                row_d = (row_q == CNT_LAST) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge rst_int) begin
        if (rst_int) begin
            r2_q       <= '0;
            row_last_q <= 1'b0;
            last_q     <= 1'b0;
            v2_q       <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            v2_q  <= v1_q;
            col_q <= col_d;
            row_q <= row_d;
            if (v1_q) begin
                r2_q       <= r2_d;
                row_last_q <= row_last_d;
                last_q     <= last_d;
            end
        end
    end

    // Output FIFO; the pointer wrap bit separates full from empty.
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             overflow_q;
    logic             empty, full, pop, push;
    logic [ENT_W-1:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && i_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign push  = v2_q && (!full || pop);

    always_ff @(posedge i_clk or posedge rst_int) begin
        if (rst_int) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {last_q, row_last_q, r2_q};
                wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (v2_q && !push) overflow_q <= 1'b1;
        end
    end

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign o_data     = head[OUT_WIDTH-1:0];
    assign o_row_last = head[OUT_WIDTH];
    assign o_last     = head[OUT_WIDTH+1];
    assign o_valid    = !empty;
    assign o_overflow = overflow_q;

endmodule
